// File: rtl/fm_ram_player.sv
// fm_ram_player: paced RAM playback sequencer feeding frequency shifts to the FM modulator.
// Define FM_PLAYER_LOOP_EN to repeat the table forever instead of halting after i_last.
module fm_ram_player #(
    parameter int p_div_sz  = 16,
    parameter int p_addr_sz = 11,
    parameter int p_data_sz = 16
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_en,
    input  logic [p_div_sz-1:0]  i_div,
    input  logic [p_addr_sz-1:0] i_last,
    output logic                 o_req,
    output logic [p_addr_sz-1:0] o_addr,
    input  logic                 i_acc,
    input  logic [p_data_sz-1:0] i_rdata,
    output logic [p_data_sz-1:0] o_shift_hz,
    output logic                 o_set,
    output logic                 o_underrun,
    output logic                 o_done
);
    typedef enum logic [1:0] {IDLE, WAIT, REQ, HALT} state_t;

    localparam logic [p_div_sz-1:0]  div_one  = {{(p_div_sz-1){1'b0}}, 1'b1};
    localparam logic [p_addr_sz-1:0] addr_one = {{(p_addr_sz-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [p_div_sz-1:0]    div_q, div_d;
    logic [p_addr_sz-1:0]   addr_q, addr_d;
    logic [p_data_sz-1:0]   shift_q, shift_d;
    logic                   set_q, set_d;
    logic                   under_q, under_d;
    logic                   done_q, done_d;
    logic                   tick;
    logic                   at_last;

    assign tick       = div_q == i_div;
    assign at_last    = addr_q == i_last;
    // request is gated by accept so the arbiter sees it drop in the accept cycle
    assign o_req      = (state_q == REQ) && !i_acc;
    assign o_addr     = addr_q;
    assign o_shift_hz = shift_q;
    assign o_set      = set_q;
    assign o_underrun = under_q;
    assign o_done     = done_q;

    // next state: sample divider, read handshake, end-of-table rule, enable override
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        set_d   = 1'b0;
        under_d = under_q;
        done_d  = done_q;
        if (state_q == WAIT || state_q == REQ)
            div_d = tick ? '0 : div_q + div_one;
        case (state_q)
            IDLE: state_d = REQ;
            WAIT: state_d = tick ? REQ : WAIT;
            REQ: begin
                if (tick && !i_acc)
                    under_d = 1'b1;
                if (i_acc) begin
                    set_d   = 1'b1;
                    shift_d = i_rdata;
                    if (at_last) begin
`ifdef FM_PLAYER_LOOP_EN
                        addr_d  = '0;
                        state_d = WAIT;
`else
                        state_d = HALT;
                        done_d  = 1'b1;
`endif
                    end else begin
                        addr_d  = addr_q + addr_one;
                        state_d = WAIT;
                    end
                end
            end
            default: state_d = HALT;
        endcase
        if (!i_en) begin
            state_d = IDLE;
            div_d   = '0;
            addr_d  = '0;
            shift_d = shift_q;
            set_d   = 1'b0;
            under_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    // state registers; reset discards any read in flight
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            div_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            set_q   <= 1'b0;
            under_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            set_q   <= set_d;
            under_q <= under_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_fm_ram_player.sv
// tb_fm_ram_player: randomized and directed playback runs checked against a sample-schedule model.
module tb_fm_ram_player;
`ifdef FM_PLAYER_LOOP_EN
    localparam bit loop_en = 1'b1;
`else
    localparam bit loop_en = 1'b0;
`endif
    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic        i_en = 1'b0;
    logic [15:0] i_div = '0;
    logic [10:0] i_last = '0;
    logic        o_req;
    logic [10:0] o_addr;
    logic        i_acc = 1'b0;
    logic [15:0] i_rdata = '0;
    logic [15:0] o_shift_hz;
    logic        o_set;
    logic        o_underrun;
    logic        o_done;

    fm_ram_player dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_en(i_en), .i_div(i_div), .i_last(i_last),
        .o_req(o_req), .o_addr(o_addr), .i_acc(i_acc), .i_rdata(i_rdata),
        .o_shift_hz(o_shift_hz), .o_set(o_set), .o_underrun(o_underrun), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [15:0] mem [2048];
    int          tests = 0, fails = 0;
    bit          pending, halted, acc_given, exp_under, exp_done;
    int          s_cyc, waitc, lat, lat_fixed, lat_rmax, next_start, exp_idx;
    logic [15:0] fire_data, last_shift;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        pending = 0; halted = 0; acc_given = 0; exp_under = 0; exp_done = 0; exp_idx = 0;
    endtask

    // one clock: check outputs against the schedule model, then play the arbiter
    task automatic step(output bit accepted);
        bit en_s, fire;
        int t0;
        accepted = 0;
        @(posedge i_clk);
        en_s = i_en;
        fire = acc_given && en_s;
        acc_given = 0;
        #1 i_acc = 1'b0;
        #1;
        chk("o_set", o_set, fire);
        if (fire) begin
            chk("shift", o_shift_hz, fire_data);
            chk("underrun", o_underrun, exp_under);
            last_shift = fire_data;
        end
        if (!en_s) begin
            model_clear();
            chk("idle_req", o_req, 0);
            chk("idle_addr", o_addr, 0);
            chk("idle_under", o_underrun, 0);
            chk("idle_done", o_done, 0);
            chk("idle_shift", o_shift_hz, last_shift);
            next_start = cyc + 1;
            return;
        end
        chk("done", o_done, exp_done);
        if (!pending) begin
            chk("req_start", o_req, !halted && cyc == next_start);
            if (o_req === 1'b1) begin
                pending = 1; s_cyc = cyc; waitc = 0;
                lat = lat_fixed >= 0 ? lat_fixed : int'($urandom_range(0, lat_rmax));
            end
        end else chk("req_hold", o_req, 1);
        if (pending) begin
            chk("addr", o_addr, exp_idx);
            if (waitc == lat) begin
                i_acc = 1'b1;
                i_rdata = mem[o_addr];
                fire_data = mem[exp_idx];
                acc_given = 1; accepted = 1; pending = 0;
                if (cyc - s_cyc > int'(i_div)) exp_under = 1;
                t0 = s_cyc + int'(i_div);
                if (cyc >= t0) t0 += ((cyc - t0) / (int'(i_div) + 1) + 1) * (int'(i_div) + 1);
                next_start = t0 + 1;
                if (exp_idx == int'(i_last)) begin
                    if (loop_en) exp_idx = 0;
                    else begin halted = 1; exp_done = 1; end
                end else exp_idx = (exp_idx + 1) % 2048;
            end else waitc++;
        end
    endtask

    task automatic run(input int n);
        bit a;
        repeat (n) step(a);
    endtask

    initial begin
        bit a;
        int k;
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        model_clear();
        last_shift = '0; lat_fixed = 1; lat_rmax = 0; next_start = 0;
        #3;
        chk("rst_req", o_req, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_shift", o_shift_hz, 0);
        chk("rst_set", o_set, 0);
        chk("rst_under", o_underrun, 0);
        chk("rst_done", o_done, 0);
        @(posedge i_clk); #1 i_nrst = 1'b1;
        run(2);

        // basic table: div 9, four words, one-cycle arbiter
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        i_div = 16'd9; i_last = 11'd3; lat_fixed = 1;
        i_en = 1'b1;
        run(70);

        // arbiter contention causes underrun
        i_en = 1'b0; run(2);
        i_div = 16'd2; i_last = 11'd3; lat_fixed = 6;
        i_en = 1'b1;
        run(60);

        // enable drops in the accept cycle
        i_en = 1'b0; run(2);
        i_div = 16'd3; i_last = 11'd5; lat_fixed = 2;
        i_en = 1'b1;
        k = 0; a = 0;
        while (!a && k < 100) begin step(a); k++; end
        chk("acc_seen", a, 1);
        i_en = 1'b0;
        run(3);

        // asynchronous reset while a read is pending
        i_div = 16'd9; i_last = 11'd3; lat_fixed = 5;
        i_en = 1'b1;
        k = 0;
        while (!pending && k < 20) begin step(a); k++; end
        chk("pend_seen", pending, 1);
        #2 i_nrst = 1'b0;
        #1;
        chk("arst_req", o_req, 0);
        chk("arst_addr", o_addr, 0);
        chk("arst_shift", o_shift_hz, 0);
        chk("arst_set", o_set, 0);
        chk("arst_under", o_underrun, 0);
        chk("arst_done", o_done, 0);
        i_acc = 1'b0;
        @(posedge i_clk); #1;
        chk("arst_hold_set", o_set, 0);
        i_nrst = 1'b1;
        model_clear(); last_shift = '0; next_start = cyc + 1;
        run(40);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            i_en = 1'b0; run(2);
            for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
            i_div = 16'($urandom_range(0, 4));
            i_last = 11'($urandom_range(0, 6));
            lat_fixed = -1; lat_rmax = $urandom_range(0, 6);
            i_en = 1'b1;
            run(80);
        end

        // full table with top-of-range address, tick every cycle
        i_en = 1'b0; run(2);
        i_div = 16'd0; i_last = 11'h7FF; lat_fixed = 0;
        i_en = 1'b1;
        run(6200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
